// File: rtl/clb_cfg_loader.sv
// +--------------------------------------------------------------------------+
// | clb_cfg_loader: framed byte-stream loader for CLB LUT / FF-select config  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module clb_cfg_loader #(
  parameter int NUM_CLB = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_valid,
  input  logic [7:0]             cfg_data,
  output logic                   cfg_ready,
  output logic [16*NUM_CLB-1:0]  lut_mem_o,
  output logic [NUM_CLB-1:0]     sel_ff_o,
  output logic                   cfg_busy,
  output logic                   cfg_done,
  output logic                   cfg_err
);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_COUNT  = 3'd1,
    S_DATA   = 3'd2,
    S_CHECK  = 3'd3,
    S_COMMIT = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  n_q, n_d;
  logic [7:0]  clb_q, clb_d;
  logic [7:0]  xor_q, xor_d;
  logic [1:0]  byte_q, byte_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        accept;
  logic        shadow_we;
  logic        commit;

  logic [15:0]        shadow_lut_q [NUM_CLB];
  logic [NUM_CLB-1:0] shadow_sel_q;
  logic [15:0]        active_lut_q [NUM_CLB];
  logic [NUM_CLB-1:0] active_sel_q;

  assign cfg_ready = (state_q != S_COMMIT);
  assign cfg_busy  = (state_q != S_IDLE);
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;
  assign accept    = cfg_valid && cfg_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      n_q     <= 8'd0;
      clb_q   <= 8'd0;
      xor_q   <= 8'd0;
      byte_q  <= 2'd0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      clb_q   <= clb_d;
      xor_q   <= xor_d;
      byte_q  <= byte_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    clb_d     = clb_q;
    xor_d     = xor_q;
    byte_d    = byte_q;
    err_d     = err_q;
    shadow_we = 1'b0;
    commit    = 1'b0;
    done_d    = (state_q == S_COMMIT);

    case (state_q)
      S_IDLE: begin
        if (accept && cfg_data == SYNC_BYTE) begin
          state_d = S_COUNT;
          err_d   = 1'b0;
        end
      end

      S_COUNT: begin
        if (accept) begin
          if (cfg_data == 8'd0 || cfg_data > 8'(NUM_CLB)) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end else begin
            state_d = S_DATA;
            n_d     = cfg_data;
            clb_d   = 8'd0;
            byte_d  = 2'd0;
            // Checksum restarts here, so N is its first term.
            xor_d   = cfg_data;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          shadow_we = 1'b1;
          xor_d     = xor_q ^ cfg_data;
          if (byte_q == 2'd2) begin
            byte_d = 2'd0;
            if (clb_q == n_q - 8'd1) begin
              state_d = S_CHECK;
            end else begin
              clb_d = clb_q + 8'd1;
            end
          end else begin
            byte_d = byte_q + 2'd1;
          end
        end
      end

      S_CHECK: begin
        if (accept) begin
          if (cfg_data == xor_q) begin
            state_d = S_COMMIT;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end
      end

      S_COMMIT: begin
        commit  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Shadow staging and atomic copy into the active bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CLB; i++) begin
        shadow_lut_q[i] <= 16'd0;
        active_lut_q[i] <= 16'd0;
      end
      shadow_sel_q <= '0;
      active_sel_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CLB; i++) begin
        if (shadow_we && clb_q == 8'(i)) begin
          case (byte_q)
            2'd0:    shadow_lut_q[i][7:0]  <= cfg_data;
            2'd1:    shadow_lut_q[i][15:8] <= cfg_data;
            2'd2:    shadow_sel_q[i]       <= cfg_data[0];
            default: ;
          endcase
        end
        if (commit && 8'(i) < n_q) begin
          active_lut_q[i] <= shadow_lut_q[i];
          active_sel_q[i] <= shadow_sel_q[i];
        end
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_CLB; g++) begin : g_out
      assign lut_mem_o[16*g +: 16] = active_lut_q[g];
    end
  endgenerate

  assign sel_ff_o = active_sel_q;

endmodule

`default_nettype wire

// File: tb/tb_clb_cfg_loader.sv
// +--------------------------------------------------------------------------+
// | tb_clb_cfg_loader: directed self-checking bench for clb_cfg_loader        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_clb_cfg_loader;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic [7:0]  cfg_data;
  logic        cfg_ready;
  logic [63:0] lut_mem_o;
  logic [3:0]  sel_ff_o;
  logic        cfg_busy;
  logic        cfg_done;
  logic        cfg_err;

  int checks = 0;
  int passed = 0;
  int ready_low_cnt = 0;
  logic [7:0] fr[$];

  clb_cfg_loader #(.NUM_CLB(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .lut_mem_o (lut_mem_o),
    .sel_ff_o  (sel_ff_o),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (!cfg_ready) ready_low_cnt <= ready_low_cnt + 1;

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_data  = b;
    while (!cfg_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!cfg_ready) begin
      checks++;
      $display("FAIL send_timeout ready=%b required 1", cfg_ready);
      cfg_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
    end
  endtask

  task automatic send_fr(input bit gaps);
    foreach (fr[i]) begin
      send(fr[i]);
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (lut_mem_o !== 64'd0) $display("FAIL rst_lut got=%h exp=0", lut_mem_o); else passed++;
    checks++; if (sel_ff_o !== 4'd0) $display("FAIL rst_sel got=%b exp=0", sel_ff_o); else passed++;
    checks++; if ({cfg_ready, cfg_busy, cfg_done, cfg_err} !== 4'b1000)
      $display("FAIL rst_ctrl got=%b exp=1000", {cfg_ready, cfg_busy, cfg_done, cfg_err}); else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    fr = '{8'hA5, 8'h01, 8'h34, 8'h12, 8'h01, 8'h26};
    send_fr(1'b0);
    @(negedge clk);
    checks++; if ({cfg_ready, cfg_busy, cfg_done} !== 3'b010)
      $display("FAIL single_commit_cycle got=%b exp=010", {cfg_ready, cfg_busy, cfg_done}); else passed++;
    checks++; if (lut_mem_o !== 64'd0) $display("FAIL single_early_lut got=%h exp=0", lut_mem_o); else passed++;
    @(negedge clk);
    checks++; if (lut_mem_o !== 64'h0000_0000_0000_1234)
      $display("FAIL single_lut got=%h exp=0000000000001234", lut_mem_o); else passed++;
    checks++; if (sel_ff_o !== 4'b0001) $display("FAIL single_sel got=%b exp=0001", sel_ff_o); else passed++;
    checks++; if ({cfg_done, cfg_err, cfg_ready} !== 3'b101)
      $display("FAIL single_done got=%b exp=101", {cfg_done, cfg_err, cfg_ready}); else passed++;
    @(negedge clk);
    checks++; if (cfg_done !== 1'b0) $display("FAIL single_done_pulse got=%b exp=0", cfg_done); else passed++;
  endtask

  task automatic test_bad_chk();
    pulse_reset();
    fr = '{8'hA5, 8'h01, 8'h34, 8'h12, 8'h01, 8'h27};
    send_fr(1'b0);
    @(negedge clk);
    checks++; if ({cfg_err, cfg_busy} !== 2'b10)
      $display("FAIL badchk_err got=%b exp=10", {cfg_err, cfg_busy}); else passed++;
    @(negedge clk);
    checks++; if ({cfg_done, cfg_err} !== 2'b01)
      $display("FAIL badchk_nodone got=%b exp=01", {cfg_done, cfg_err}); else passed++;
    checks++; if (lut_mem_o !== 64'd0 || sel_ff_o !== 4'd0)
      $display("FAIL badchk_out got=%h/%b exp=0/0", lut_mem_o, sel_ff_o); else passed++;
    send(8'hA5);
    checks++; if (cfg_err !== 1'b0) $display("FAIL badchk_sync_clear got=%b exp=0", cfg_err); else passed++;
    fr = '{8'h01, 8'hCD, 8'hAB, 8'h00, 8'h67};
    send_fr(1'b0);
    repeat (2) @(negedge clk);
    checks++; if (lut_mem_o !== 64'h0000_0000_0000_ABCD || sel_ff_o !== 4'b0000 || cfg_done !== 1'b1)
      $display("FAIL badchk_recover got=%h/%b/%b exp=000000000000abcd/0000/1",
               lut_mem_o, sel_ff_o, cfg_done); else passed++;
  endtask

  task automatic test_bad_n();
    fr = '{8'hA5, 8'h00};
    send_fr(1'b0);
    @(negedge clk);
    checks++; if ({cfg_err, cfg_busy} !== 2'b10)
      $display("FAIL badn0_err got=%b exp=10", {cfg_err, cfg_busy}); else passed++;
    send(8'hA5);
    checks++; if (cfg_err !== 1'b0) $display("FAIL badn_sync_clear got=%b exp=0", cfg_err); else passed++;
    send(8'h05);
    @(negedge clk);
    checks++; if ({cfg_err, cfg_busy} !== 2'b10)
      $display("FAIL badn5_err got=%b exp=10", {cfg_err, cfg_busy}); else passed++;
    checks++; if (lut_mem_o !== 64'h0000_0000_0000_ABCD || sel_ff_o !== 4'b0000)
      $display("FAIL badn_out got=%h/%b exp=000000000000abcd/0000", lut_mem_o, sel_ff_o); else passed++;
  endtask

  task automatic test_gaps_full();
    int start_cnt;
    start_cnt = ready_low_cnt;
    send(8'h00);
    send(8'hFF);
    @(negedge clk);
    checks++; if ({cfg_busy, cfg_err} !== 2'b01)
      $display("FAIL junk_idle got=%b exp=01", {cfg_busy, cfg_err}); else passed++;
    fr = '{8'hA5, 8'h04, 8'hA5, 8'h11, 8'h01, 8'h22, 8'h33, 8'h00,
           8'h44, 8'h55, 8'hFE, 8'h66, 8'h77, 8'h03};
    send_fr(1'b1);
    @(negedge clk);
    checks++; if (lut_mem_o !== 64'h0000_0000_0000_ABCD || cfg_busy !== 1'b1)
      $display("FAIL full_pre_chk got=%h/%b exp=000000000000abcd/1", lut_mem_o, cfg_busy); else passed++;
    send(8'h5D);
    repeat (2) @(negedge clk);
    checks++; if (lut_mem_o !== 64'h7766_5544_3322_11A5)
      $display("FAIL full_lut got=%h exp=77665544332211a5", lut_mem_o); else passed++;
    checks++; if (sel_ff_o !== 4'b1001) $display("FAIL full_sel got=%b exp=1001", sel_ff_o); else passed++;
    checks++; if ({cfg_done, cfg_err} !== 2'b10)
      $display("FAIL full_done got=%b exp=10", {cfg_done, cfg_err}); else passed++;
    @(negedge clk);
    checks++; if (ready_low_cnt - start_cnt !== 1)
      $display("FAIL full_ready_low got=%0d exp=1", ready_low_cnt - start_cnt); else passed++;
  endtask

  task automatic test_partial();
    fr = '{8'hA5, 8'h02, 8'h0F, 8'hF0, 8'h00, 8'h5A, 8'hC3, 8'h01, 8'h65};
    send_fr(1'b0);
    repeat (2) @(negedge clk);
    checks++; if (lut_mem_o !== 64'h7766_5544_C35A_F00F)
      $display("FAIL partial_lut got=%h exp=77665544c35af00f", lut_mem_o); else passed++;
    checks++; if (sel_ff_o !== 4'b1010 || cfg_done !== 1'b1)
      $display("FAIL partial_sel got=%b/%b exp=1010/1", sel_ff_o, cfg_done); else passed++;
  endtask

  task automatic test_mid_reset();
    fr = '{8'hA5, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
    send_fr(1'b0);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (lut_mem_o !== 64'd0 || sel_ff_o !== 4'd0)
      $display("FAIL midrst_out got=%h/%b exp=0/0", lut_mem_o, sel_ff_o); else passed++;
    checks++; if ({cfg_ready, cfg_busy, cfg_done, cfg_err} !== 4'b1000)
      $display("FAIL midrst_ctrl got=%b exp=1000", {cfg_ready, cfg_busy, cfg_done, cfg_err}); else passed++;
    @(negedge clk);
    rst = 1'b0;
    fr = '{8'hA5, 8'h02, 8'h10, 8'h00, 8'h00, 8'h20, 8'h00, 8'h01, 8'h33};
    send_fr(1'b0);
    repeat (2) @(negedge clk);
    checks++; if (lut_mem_o !== 64'h0000_0000_0020_0010)
      $display("FAIL midrst_reload_lut got=%h exp=0000000000200010", lut_mem_o); else passed++;
    checks++; if (sel_ff_o !== 4'b0010 || cfg_done !== 1'b1)
      $display("FAIL midrst_reload_sel got=%b/%b exp=0010/1", sel_ff_o, cfg_done); else passed++;
  endtask

  initial begin
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_data  = 8'h00;
    test_reset();
    test_single();
    test_bad_chk();
    test_bad_n();
    test_gaps_full();
    test_partial();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
